// File: rtl/add_serial_unsigned.sv
// add_serial_unsigned: digit-serial unsigned adder.
//   Produces result = (A + B) mod 2^WIDTH and a carry-out flag, consuming DIGIT
//   bits of each operand per clock, with valid/ready handshakes on both sides.
// Optional build macro: ADD_SERIAL_SAT_EN
//   When defined, a result whose true sum overflows WIDTH is clamped to all-ones
//   on entry to DONE (carry still reads 1). Latency and handshakes are unchanged.
module add_serial_unsigned #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // Number of digit iterations per operation and the counter that tracks them.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Refuse to elaborate when the operand does not split into whole digits.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : gBadDigit
    $error("add_serial_unsigned: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers: the low DIGIT bits are the digit being added.
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  // Partial sum fills from the MS end so it is in place after N digits.
  logic [WIDTH-1:0] resSh_q;
  logic             carryReg_q;
  logic [CNT_W-1:0] cnt_q;

  // Architectural outputs, only refreshed on entry to DONE.
  logic [WIDTH-1:0] result_q;
  logic             carryOut_q;

  // Per-digit arithmetic and helpers.
  logic [DIGIT:0]       digitSum;
  logic [WIDTH+DIGIT-1:0] resShWide;
  logic [WIDTH-1:0]     resShNext;
  logic [WIDTH-1:0]     finalResult;
  logic                 lastIter;

  // One digit of the addition: two DIGIT-bit slices plus the running carry.
  always_comb begin
    digitSum = {1'b0, aSh_q[DIGIT-1:0]}
             + {1'b0, bSh_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carryReg_q};
  end

  // Insert the new sum digit at the top of the partial result; written as a
  // wide shift so that DIGIT == WIDTH needs no special-case slice.
  always_comb begin
    resShWide = {digitSum[DIGIT-1:0], resSh_q} >> DIGIT;
    resShNext = resShWide[WIDTH-1:0];
  end

  assign lastIter = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

`ifdef ADD_SERIAL_SAT_EN
  // Clamp to all-ones when the final digit produces a carry out of WIDTH.
  always_comb begin
    finalResult = resShNext;
    if (digitSum[DIGIT]) begin
      finalResult = {WIDTH{1'b1}};
    end
  end
`else
  // Plain modulo-2^WIDTH result: the final shifted partial sum.
  always_comb begin
    finalResult = resShNext;
  end
`endif

  // State register; reset lands in IDLE so in_ready is high during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate N digits in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Operand capture and the serial add datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSh_q      <= '0;
      bSh_q      <= '0;
      resSh_q    <= '0;
      carryReg_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            aSh_q      <= A;
            bSh_q      <= B;
            resSh_q    <= '0;
            carryReg_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        ST_RUN: begin
          aSh_q      <= aSh_q >> DIGIT;
          bSh_q      <= bSh_q >> DIGIT;
          resSh_q    <= resShNext;
          carryReg_q <= digitSum[DIGIT];
          cnt_q      <= cnt_q + CNT_W'(1);
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Result/carry are loaded on the RUN->DONE edge and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      carryOut_q <= 1'b0;
    end else if (lastIter) begin
      result_q   <= finalResult;
      carryOut_q <= digitSum[DIGIT];
    end
  end

  assign result = result_q;
  assign carry  = carryOut_q;

endmodule

// File: tb/tb_add_serial_unsigned.sv
// tb_add_serial_unsigned: directed plus random checks of the digit-serial adder,
// with a scoreboard of expected {carry,result} values keyed to input handshakes.
module tb_add_serial_unsigned;

`ifdef ADD_SERIAL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       inValid = 1'b0;
   logic       inReady;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       outValid;
   logic       outReady = 1'b0;
   logic [7:0] res;
   logic       carryOut;

   logic       swValid = 1'b0;
   logic [7:0] swA = 8'h00;
   logic [7:0] swB = 8'h00;
   logic       swOutReady = 1'b1;
   logic       sw1InReady, sw1OutValid, sw1Carry;
   logic [7:0] sw1Result;
   logic       sw8InReady, sw8OutValid, sw8Carry;
   logic [7:0] sw8Result;

   int         checkCount = 0;
   int         passCount = 0;
   int         failCount = 0;
   int         inCount = 0;
   int         outCount = 0;
   bit         lastInHs = 1'b0;
   logic [8:0] sbQueue[$];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   add_serial_unsigned #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady), .A(a), .B(b),
      .out_valid(outValid), .out_ready(outReady),
      .result(res), .carry(carryOut)
   );

   add_serial_unsigned #(.WIDTH(8), .DIGIT(1)) dutD1 (
      .clk(clk), .rst(rst),
      .in_valid(swValid), .in_ready(sw1InReady), .A(swA), .B(swB),
      .out_valid(sw1OutValid), .out_ready(swOutReady),
      .result(sw1Result), .carry(sw1Carry)
   );

   add_serial_unsigned #(.WIDTH(8), .DIGIT(8)) dutD8 (
      .clk(clk), .rst(rst),
      .in_valid(swValid), .in_ready(sw8InReady), .A(swA), .B(swB),
      .out_valid(sw8OutValid), .out_ready(swOutReady),
      .result(sw8Result), .carry(sw8Carry)
   );

   // Reference: 9-bit true sum, clamped low byte when saturation is built in.
   function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (SAT && s[8]) s[7:0] = 8'hFF;
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Record handshakes seen in this cycle, then advance to 1 ns after the next edge.
   task automatic tick();
      logic [8:0] expSum;
      lastInHs = 1'b0;
      if (!rst && inValid && inReady) begin
         sbQueue.push_back(model(a, b));
         inCount++;
         lastInHs = 1'b1;
      end
      if (!rst && outValid && outReady) begin
         checkOutput("sb_has_entry", (sbQueue.size() != 0), 1);
         if (sbQueue.size() != 0) begin
            expSum = sbQueue.pop_front();
            checkOutput("sb_result", res, expSum[7:0]);
            checkOutput("sb_carry", carryOut, expSum[8]);
         end
         outCount++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [7:0] y);
      inValid = v;
      a = x;
      b = y;
   endtask

   // Wait (bounded) for out_valid; reports the number of cycles waited.
   task automatic waitOut(input string tag, output int lat);
      lat = 0;
      while (!outValid && lat < 40) begin
         tick();
         lat++;
      end
      if (!outValid) checkOutput({tag, "_timeout"}, outValid, 1);
   endtask

   // One complete operation with out_ready held high.
   task automatic doOp(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [8:0] expSum, input int expLat);
      int lat;
      int g;
      outReady = 1'b1;
      applyStimulus(1'b1, x, y);
      g = 0;
      while (!inReady && g < 40) begin
         tick();
         g++;
      end
      checkOutput({tag, "_in_ready"}, inReady, 1);
      tick();
      applyStimulus(1'b0, ~x, 8'h5A);
      waitOut(tag, lat);
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_sum"}, {carryOut, res}, expSum);
      tick();
      checkOutput({tag, "_in_ready_after"}, inReady, 1);
      checkOutput({tag, "_out_valid_after"}, outValid, 0);
   endtask

   initial begin
      int lat;
      int first1;
      int first8;
      int guard;
      int pulses;
      logic [8:0] cap1;
      logic [8:0] cap8;
      logic [8:0] sweepExp;

      // Reset state while rst is still held.
      #1;
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_result", res, 8'h00);
      checkOutput("rst_carry", carryOut, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // DIGIT=1 and DIGIT=8 instances: 0x80+0x80, latency 8 and 1.
      sweepExp = SAT ? 9'h1FF : 9'h100;
      swA = 8'h80; swB = 8'h80; swValid = 1'b1;
      checkOutput("sweep_d1_in_ready", sw1InReady, 1);
      checkOutput("sweep_d8_in_ready", sw8InReady, 1);
      tick();
      swValid = 1'b0; swA = 8'h00; swB = 8'h00;
      first1 = 0; first8 = 0; cap1 = '0; cap8 = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (sw1OutValid && first1 == 0) begin first1 = i; cap1 = {sw1Carry, sw1Result}; end
         if (sw8OutValid && first8 == 0) begin first8 = i; cap8 = {sw8Carry, sw8Result}; end
      end
      checkOutput("sweep_d1_latency", first1, 8);
      checkOutput("sweep_d8_latency", first8, 1);
      checkOutput("sweep_d1_sum", cap1, sweepExp);
      checkOutput("sweep_d8_sum", cap8, sweepExp);

      // Basic operations and the arithmetic corner cases.
      doOp("op_35_12", 8'h35, 8'h12, 9'h047, 4);
      doOp("op_ff_01", 8'hFF, 8'h01, SAT ? 9'h1FF : 9'h100, 4);
      doOp("op_00_00", 8'h00, 8'h00, 9'h000, 4);
      doOp("op_ff_ff", 8'hFF, 8'hFF, SAT ? 9'h1FF : 9'h1FE, 4);
      doOp("op_0f_f0", 8'h0F, 8'hF0, 9'h0FF, 4);

      // Backpressure: output held for five cycles, new input ignored.
      outReady = 1'b0;
      applyStimulus(1'b1, 8'h80, 8'h7F);
      tick();
      applyStimulus(1'b1, 8'h11, 8'h22);
      waitOut("bp", lat);
      checkOutput("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_out_valid", outValid, 1);
         checkOutput("bp_result", res, 8'hFF);
         checkOutput("bp_carry", carryOut, 0);
         checkOutput("bp_in_ready", inReady, 0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00);
      outReady = 1'b1;
      tick();
      checkOutput("bp_in_ready_after", inReady, 1);
      checkOutput("bp_sb_empty", sbQueue.size(), 0);

      // Reset during the second RUN cycle aborts the operation.
      applyStimulus(1'b1, 8'hAA, 8'h55);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_in_ready", inReady, 1);
      checkOutput("mid_rst_out_valid", outValid, 0);
      checkOutput("mid_rst_result", res, 8'h00);
      checkOutput("mid_rst_carry", carryOut, 0);
      sbQueue.delete();
      pulses = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (outValid) pulses++;
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (outValid) pulses++;
      end
      checkOutput("mid_rst_no_pulse", pulses, 0);
      doOp("after_rst", 8'h01, 8'h02, 9'h003, 4);

      // Random back-to-back traffic with random output backpressure.
      inCount = 0;
      outCount = 0;
      sbQueue.delete();
      applyStimulus(1'b1, 8'($urandom), 8'($urandom));
      guard = 0;
      while (inCount < 1000 && guard < 40000) begin
         outReady = 1'($urandom_range(0, 1));
         tick();
         guard++;
         if (lastInHs) begin
            case ($urandom_range(0, 7))
               0: applyStimulus(1'b1, 8'hFF, 8'($urandom));
               1: applyStimulus(1'b1, 8'($urandom), 8'h00);
               default: applyStimulus(1'b1, 8'($urandom), 8'($urandom));
            endcase
            if (inCount >= 1000) inValid = 1'b0;
         end
      end
      inValid = 1'b0;
      outReady = 1'b1;
      guard = 0;
      while (sbQueue.size() != 0 && guard < 50) begin
         tick();
         guard++;
      end
      checkOutput("rand_in_count", inCount, 1000);
      checkOutput("rand_sb_drained", sbQueue.size(), 0);
      checkOutput("rand_out_count", outCount, inCount);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
